// File: rtl/down_counter4bit.sv
// Loadable down counter with borrow chain, wrap/one-shot modes and a sticky DONE flag.
// Optional macro DOWN_CNT_AUTORELOAD_EN: wrap reloads from the last loaded value instead of all-ones.
module down_counter4bit #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             BI,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             BO,
  output logic             ZERO,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_nq;
  logic             r_done;
  logic             w_ce;
  logic             w_zero;
  logic             w_d_zero;
  logic [WIDTH-1:0] w_q_dec;
  logic [WIDTH-1:0] w_wrap;

  assign w_ce     = EN & BI;
  assign w_zero   = (r_q == {WIDTH{1'b0}});
  assign w_d_zero = (D == {WIDTH{1'b0}});
  assign w_q_dec  = r_q - {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef DOWN_CNT_AUTORELOAD_EN
  logic [WIDTH-1:0] r_rld;

  // Reload register tracks the most recent parallel load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rld <= RST_VAL;
    end else if (LOAD) begin
      r_rld <= D;
    end
  end

  assign w_wrap = r_rld;
`else
  assign w_wrap = {WIDTH{1'b1}};
`endif

  // Counter FSM: reset, then load, then count enable, else hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q     <= RST_VAL;
      r_nq    <= ~RST_VAL;
      r_done  <= 1'b0;
      r_state <= S_IDLE;
    end else if (LOAD) begin
      r_q     <= D;
      r_nq    <= ~D;
      r_done  <= w_d_zero;
      r_state <= w_d_zero ? S_EXPIRED : S_RUN;
    end else if (w_ce) begin
      case (r_state)
        S_IDLE, S_RUN: begin
          r_state <= S_RUN;
          if (!w_zero) begin
            r_q  <= w_q_dec;
            r_nq <= ~w_q_dec;
          end else if (!MODE) begin
            r_q  <= w_wrap;
            r_nq <= ~w_wrap;
          end else begin
            // One-shot expires when the zero count is consumed, not on reaching it.
            r_state <= S_EXPIRED;
            r_done  <= 1'b1;
          end
        end
        S_EXPIRED: begin
          r_state <= S_EXPIRED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Q    = r_q;
  assign NQ   = r_nq;
  assign DONE = r_done;
  assign ZERO = w_zero;
  assign BO   = w_ce & w_zero & ~(MODE & (r_state == S_EXPIRED));

endmodule

// File: tb/tb_down_counter4bit.sv
// Directed table-driven bench for down_counter4bit, plus cascade and reload sequences.
module tb_down_counter4bit;

  logic       clk;
  logic       rst, load, en, bi, mode;
  logic [3:0] d;
  logic [3:0] q, nq;
  logic       bo, zero, done;

  // cascade pair
  logic       c_rst, c_load, c_en, c_mode;
  logic [3:0] c_d_lo, c_d_hi;
  logic [3:0] lo_q, lo_nq, hi_q, hi_nq;
  logic       lo_bo, lo_zero, lo_done, hi_bo, hi_zero, hi_done;

  int n_cmp = 0;
  int n_err = 0;

  down_counter4bit u_dut (
    .CLK(clk), .RST(rst), .LOAD(load), .D(d), .EN(en), .BI(bi), .MODE(mode),
    .Q(q), .NQ(nq), .BO(bo), .ZERO(zero), .DONE(done)
  );

  down_counter4bit u_lo (
    .CLK(clk), .RST(c_rst), .LOAD(c_load), .D(c_d_lo), .EN(c_en), .BI(1'b1), .MODE(c_mode),
    .Q(lo_q), .NQ(lo_nq), .BO(lo_bo), .ZERO(lo_zero), .DONE(lo_done)
  );

  down_counter4bit u_hi (
    .CLK(clk), .RST(c_rst), .LOAD(c_load), .D(c_d_hi), .EN(c_en), .BI(lo_bo), .MODE(c_mode),
    .Q(hi_q), .NQ(hi_nq), .BO(hi_bo), .ZERO(hi_zero), .DONE(hi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, load, en, bi, mode;
    logic [3:0] d;
    logic [3:0] eq;
    logic       edone, ebo;
  } vec_t;

  vec_t vt[23];

  initial begin
    logic [3:0] w5, w6, w21;
`ifdef DOWN_CNT_AUTORELOAD_EN
    w5 = 4'h2; w6 = 4'h1; w21 = 4'h1;
`else
    w5 = 4'hF; w6 = 4'hE; w21 = 4'hF;
`endif
    //           rst   load  en    bi    mode  d      q      done  bo
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'hF, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'h2, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, w5,   1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, w6,   1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 4'h9, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h9, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    vt[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 4'hF, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0};
    vt[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};
    vt[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, w21,  1'b0, 1'b0};
    vt[21] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0};
    vt[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0};

    rst = 1'b1; load = 1'b0; en = 1'b0; bi = 1'b1; mode = 1'b0; d = 4'h0;
    c_rst = 1'b1; c_load = 1'b0; c_en = 1'b0; c_mode = 1'b0; c_d_lo = 4'h0; c_d_hi = 4'h0;
    tick();

    for (int i = 0; i < 23; i++) begin
      rst = vt[i].rst; load = vt[i].load; en = vt[i].en;
      bi = vt[i].bi; mode = vt[i].mode; d = vt[i].d;
      tick();
      check($sformatf("v%0d_q", i),    {4'h0, q},    {4'h0, vt[i].eq});
      check($sformatf("v%0d_nq", i),   {4'h0, nq},   {4'h0, ~vt[i].eq});
      check($sformatf("v%0d_zero", i), {7'h0, zero}, {7'h0, (vt[i].eq == 4'h0)});
      check($sformatf("v%0d_done", i), {7'h0, done}, {7'h0, vt[i].edone});
      check($sformatf("v%0d_bo", i),   {7'h0, bo},   {7'h0, vt[i].ebo});
    end

    // Cascade: 8'h11 -> 10 -> 0F -> 0E -> 0D; high stage moves only when low is at zero.
    c_rst = 1'b0; c_load = 1'b1; c_d_hi = 4'h1; c_d_lo = 4'h1;
    tick();
    check("casc_load", {hi_q, lo_q}, 8'h11);
    check("casc_lo_bo0", {7'h0, lo_bo}, 8'h00);
    c_load = 1'b0; c_en = 1'b1;
    tick();
    check("casc_e1", {hi_q, lo_q}, 8'h10);
    check("casc_lo_bo1", {7'h0, lo_bo}, 8'h01);
    tick();
    check("casc_e2", {hi_q, lo_q}, 8'h0F);
    check("casc_hi_bo", {7'h0, hi_bo}, 8'h00);
    tick();
    check("casc_e3", {hi_q, lo_q}, 8'h0E);
    tick();
    check("casc_e4", {hi_q, lo_q}, 8'h0D);
    c_en = 1'b0;

`ifdef DOWN_CNT_AUTORELOAD_EN
    begin
      logic [3:0] exp_ar[5];
      exp_ar[0] = 4'h2; exp_ar[1] = 4'h1; exp_ar[2] = 4'h0; exp_ar[3] = 4'h3; exp_ar[4] = 4'h2;
      rst = 1'b0; load = 1'b1; d = 4'h3; en = 1'b0; bi = 1'b1; mode = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        check($sformatf("ar_%0d", k), {4'h0, q}, {4'h0, exp_ar[k]});
      end
      rst = 1'b1; en = 1'b0;
      tick();
      check("ar_rst", {4'h0, q}, 8'h0F);
      rst = 1'b0; en = 1'b1;
      for (int k = 0; k < 16; k++) begin
        logic [3:0] e;
        e = (k == 15) ? 4'hF : 4'(14 - k);
        tick();
        check($sformatf("ar_rld_%0d", k), {4'h0, q}, {4'h0, e});
      end
      en = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/down_counter4bit.md
Name: down_counter4bit

Overview:
- Synchronous 4-bit loadable down counter; the count-down counterpart of the arithmetic unit's 4-bit ripple up counter.
- Used as a countdown, timeout and iteration timer by the arithmetic unit's sequencing logic.
- Provides a borrow chain (BI/BO) so several instances cascade into wider down counters.
- Has a wrap mode and a one-shot mode with a sticky DONE flag.

Parameters:
- WIDTH, 4, counter width in bits. The whole spec is written for 4; the RTL must stay correct for any WIDTH from 2 to 8.
- RST_VAL, 4'hF, value loaded into Q on reset.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- LOAD  input  1  load D into counter on this edge.
- D  input  WIDTH  parallel load value.
- EN  input  1  count enable.
- BI  input  1  borrow-in from the lower stage; tie to 1 for the least-significant stage.
- MODE  input  1  0 = wrap, 1 = one-shot; sampled every cycle.
- Q  output  WIDTH  count value.
- NQ  output  WIDTH  bitwise complement of Q, always ~Q.
- BO  output  1  borrow-out to the next stage, combinational.
- ZERO  output  1  Q == 0, combinational.
- DONE  output  1  registered, sticky one-shot expiry flag.

Behaviour:
- All state updates on the rising edge of CLK. Reset is synchronous, active-high and checked only at the edge.
- Reset values: Q = RST_VAL, NQ = ~RST_VAL, DONE = 0, FSM = IDLE. BO and ZERO follow Q.
- Count enable: CE = EN & BI.
- Edge priority, highest first:
  - RST: reset as above.
  - LOAD: Q <= D; DONE <= 0; FSM <= RUN if D != 0, else EXPIRED with DONE <= 1.
  - CE: decrement per the state rules below.
  - Otherwise: hold.
- FSM states:
  - IDLE: counts like RUN. The first CE edge moves to RUN, with the same decrement rules as RUN.
  - RUN, Q != 0: Q <= Q - 1.
  - RUN, Q == 0, MODE = 0: Q wraps to all-ones (4'hF); stay in RUN.
  - RUN, Q == 0, MODE = 1: Q holds 0; FSM <= EXPIRED; DONE <= 1.
  - RUN, Q == 1 with CE, MODE = 1: Q <= 0 on this edge. DONE rises on the next CE edge, when Q == 0 is consumed, not on reaching zero.
  - EXPIRED: Q frozen at 0 whatever CE is; DONE stays 1. Leave only via LOAD or RST.
- BO = CE & (Q == 0) & ~(MODE & FSM == EXPIRED). An expired one-shot stage never propagates a borrow.
- Cascading: stage n BI = stage n-1 BO, all on the same CLK. Stage n decrements on the same edge stage n-1 wraps.
- Latency:
  - LOAD to Q: 1 cycle.
  - CE to Q: 1 cycle.
  - ZERO and BO: same cycle as Q.
- Boundary cases:
  - LOAD and CE on the same edge: LOAD wins; no decrement that cycle.
  - LOAD with D = 0: immediate EXPIRED and DONE = 1, independent of MODE.
  - MODE changed mid-count: takes effect at the next Q == 0 decision.
  - RST mid-count or while EXPIRED: resets state unconditionally.
  - RST together with LOAD: RST wins.
  - EN = 1 with BI = 0: hold, BO = 0.

Optional Feature:
- Macro: DOWN_CNT_AUTORELOAD_EN.
- Defined:
  - Adds a WIDTH-bit reload register RLD; RST sets RLD = RST_VAL.
  - Every LOAD also captures D into RLD.
  - In wrap mode, a CE edge at Q == 0 loads Q <= RLD instead of 4'hF.
  - BO is unchanged.
  - Reloading RLD = 0 keeps Q at 0 with BO asserted on every CE.
- Undefined:
  - No RLD register; wrap always goes to 4'hF, as described in Behaviour.
- Ports are identical in both builds.

Test Plan:
- Reset: RST = 1 for one edge with LOAD = 1, D = 4'h3 -> Q = 4'hF, NQ = 4'h0, DONE = 0, ZERO = 0.
- Wrap count: LOAD D = 4'h2, then MODE = 0, EN = BI = 1 for 4 edges -> Q = 1, 0, F, E. BO = 1 only in the cycle Q = 0. ZERO matches.
- One-shot: LOAD D = 4'h2, MODE = 1, CE for 5 edges -> Q = 1, 0, 0, 0, 0. DONE rises after edge 3 and stays 1. BO = 1 only in the cycle before DONE rises. A following LOAD D = 4'h5 -> Q = 5, DONE = 0.
- Priority: LOAD D = 4'h9 with CE = 1 -> Q = 9 (no decrement). RST with LOAD in EXPIRED -> Q = F, DONE = 0. LOAD D = 0 -> DONE = 1 next cycle.
- Cascade: two stages with low BI = 1, start at 8'h01 -> 8'h00, 8'hFF, 8'hFE. High stage decrements only on the edge where low Q = 0. EN = 1 with BI = 0 holds.
- With DOWN_CNT_AUTORELOAD_EN defined: LOAD D = 4'h3, MODE = 0, CE for 5 edges -> 2, 1, 0, 3, 2. RST then count from F -> F, ..., 0, F (RLD = RST_VAL).
